// File: rtl/motor_pkg.sv
// Shared types, widths and helpers for the motor PWM driver.
package motor_pkg;

    localparam int unsigned PWM_W = 10;
    localparam int unsigned CMD_W = PWM_W + 1;
    localparam logic [PWM_W-1:0] DUTY_MAX = {PWM_W{1'b1}};

    typedef enum logic {RUN, DEAD} side_state_t;

    typedef logic signed [CMD_W-1:0] drv_cmd_t;

    // Unsigned duty magnitude of a signed drive command; the most negative code saturates.
    function automatic logic [PWM_W-1:0] cmd_mag(input drv_cmd_t cmd);
        logic [PWM_W-1:0] mag;
        if (!cmd[CMD_W-1]) begin
            mag = cmd[PWM_W-1:0];
        end else if (cmd[PWM_W-1:0] == '0) begin
            mag = DUTY_MAX;
        end else begin
            mag = PWM_W'(-cmd);
        end
        return mag;
    endfunction

endpackage

// File: rtl/pwm_side.sv
// One H-bridge side: command magnitude, period-boundary duty buffer,
// reversal dead-time FSM and registered forward/reverse pin drive.
module pwm_side
    import motor_pkg::*;
#(
    parameter int unsigned DEAD_PRD = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  drv_cmd_t         cmd,
    input  logic [PWM_W-1:0] cnt,
    input  logic             latch,
    output logic             fwd,
    output logic             rev
);

    localparam int unsigned       DEAD_W    = 3;
    localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_PRD);
    localparam logic [DEAD_W-1:0] DEAD_ONE  = DEAD_W'(1);

    side_state_t       state;
    side_state_t       state_nxt;
    logic [DEAD_W-1:0] dead_cnt;
    logic [DEAD_W-1:0] dead_nxt;
    logic [PWM_W-1:0]  duty_lat;
    logic              dir_lat;
    logic [PWM_W-1:0]  mag_c;
    logic              dir_c;
    logic              reversal_c;
    logic              pwm_raw_c;
    logic              fwd_nxt;
    logic              rev_nxt;

    // Live command decode; a reversal only matters if both old and new duty are nonzero.
    assign mag_c      = cmd_mag(cmd);
    assign dir_c      = cmd[CMD_W-1];
    assign reversal_c = (dir_c != dir_lat) && (mag_c != '0) && (duty_lat != '0);
    assign pwm_raw_c  = (cnt < duty_lat);

    // Next-state, dead counter and pin decode; state only moves at the period boundary.
    always_comb begin
        state_nxt = state;
        dead_nxt  = dead_cnt;
        fwd_nxt   = 1'b0;
        rev_nxt   = 1'b0;

        if (latch) begin
            if (state == RUN) begin
                if (reversal_c) begin
                    state_nxt = DEAD;
                    dead_nxt  = DEAD_LOAD;
                end
            end else begin
                if (reversal_c) begin
                    dead_nxt = DEAD_LOAD;
                end else begin
                    dead_nxt = dead_cnt - DEAD_ONE;
                    if (dead_cnt == DEAD_ONE) begin
                        state_nxt = RUN;
                    end
                end
            end
        end

        if (state == RUN) begin
            fwd_nxt = pwm_raw_c & ~dir_lat;
            rev_nxt = pwm_raw_c &  dir_lat;
        end
    end

    // State, double-buffered duty/direction and registered pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            dead_cnt <= '0;
            duty_lat <= '0;
            dir_lat  <= 1'b0;
            fwd      <= 1'b0;
            rev      <= 1'b0;
        end else begin
            state    <= state_nxt;
            dead_cnt <= dead_nxt;
            fwd      <= fwd_nxt;
            rev      <= rev_nxt;
            if (latch) begin
                duty_lat <= mag_c;
                dir_lat  <= dir_c;
            end
        end
    end

endmodule

// File: rtl/motor_pwm_drv.sv
// Dual H-bridge PWM driver: shared PWM timebase feeding two independent sides.
module motor_pwm_drv
    import motor_pkg::*;
#(
    parameter int unsigned DEAD_PRD = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [CMD_W-1:0] lft,
    input  logic signed [CMD_W-1:0] rht,
    output logic                    fwd_lft,
    output logic                    rev_lft,
    output logic                    fwd_rht,
    output logic                    rev_rht,
    output logic                    prd_strt
);

    logic [PWM_W-1:0] cnt;
    logic             latch_c;

    assign latch_c = (cnt == DUTY_MAX);

    // Free-running period counter; prd_strt lines up with the cycle cnt holds 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            prd_strt <= 1'b0;
        end else begin
            cnt      <= cnt + PWM_W'(1);
            prd_strt <= latch_c;
        end
    end

    pwm_side #(
        .DEAD_PRD (DEAD_PRD)
    ) u_side_lft (
        .clk   (clk),
        .rst_n (rst_n),
        .cmd   (lft),
        .cnt   (cnt),
        .latch (latch_c),
        .fwd   (fwd_lft),
        .rev   (rev_lft)
    );

    pwm_side #(
        .DEAD_PRD (DEAD_PRD)
    ) u_side_rht (
        .clk   (clk),
        .rst_n (rst_n),
        .cmd   (rht),
        .cnt   (cnt),
        .latch (latch_c),
        .fwd   (fwd_rht),
        .rev   (rev_rht)
    );

endmodule

// File: tb/tb_motor_pwm_drv.sv
// Bench for motor_pwm_drv: per-period expectations from a command-level model,
// checked cycle by cycle by an independent monitor.
module tb_motor_pwm_drv;

    localparam int unsigned DEAD_PRD = 1;
    localparam int          PRD      = 1024;

    typedef struct {
        int fl;
        int rl;
        int fr;
        int rr;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic signed [10:0] lft = '0;
    logic signed [10:0] rht = '0;
    logic               fwd_lft;
    logic               rev_lft;
    logic               fwd_rht;
    logic               rev_rht;
    logic               prd_strt;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    // Reference state per side: last latched duty/direction and dead periods still owed.
    int m_duty[2];
    int m_dir[2];
    int m_dead[2];

    string pin_name[4] = '{"fwd_lft", "rev_lft", "fwd_rht", "rev_rht"};

    motor_pwm_drv #(
        .DEAD_PRD (DEAD_PRD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .lft      (lft),
        .rht      (rht),
        .fwd_lft  (fwd_lft),
        .rev_lft  (rev_lft),
        .fwd_rht  (fwd_rht),
        .rev_rht  (rev_rht),
        .prd_strt (prd_strt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_duty[s] = 0;
            m_dir[s]  = 0;
            m_dead[s] = 0;
        end
    endtask

    // Command seen at the period boundary -> high-cycle counts for the side's two pins next period.
    task automatic model_side(input int s, input int cmd, output int f, output int r);
        int mag;
        int dir;
        bit flip;
        mag  = (cmd < 0) ? -cmd : cmd;
        if (mag > 1023) mag = 1023;
        dir  = (cmd < 0) ? 1 : 0;
        flip = (dir != m_dir[s]) && (mag != 0) && (m_duty[s] != 0);
        if (flip) m_dead[s] = DEAD_PRD;
        else if (m_dead[s] > 0) m_dead[s]--;
        if (m_dead[s] > 0) begin
            f = 0;
            r = 0;
        end else begin
            f = dir ? 0 : mag;
            r = dir ? mag : 0;
        end
        m_duty[s] = mag;
        m_dir[s]  = dir;
    endtask

    task automatic push_model(input int l, input int r);
        exp_t e;
        model_side(0, l, e.fl, e.rl);
        model_side(1, r, e.fr, e.rr);
        exp_q.push_back(e);
    endtask

    task automatic push_zero();
        exp_t e;
        e.fl = 0; e.rl = 0; e.fr = 0; e.rr = 0;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full period starting at cnt==0; optional intermediate value, final value at pos.
    task automatic run_period(input int l_mid, input int r_mid, input int mid_pos,
                              input int l, input int r, input int pos);
        for (int p = 0; p < PRD; p++) begin
            if (p == mid_pos) begin
                lft = 11'(l_mid);
                rht = 11'(r_mid);
            end
            if (p == pos) begin
                lft = 11'(l);
                rht = 11'(r);
            end
            tick();
        end
        push_model(l, r);
    endtask

    task automatic run(input int l, input int r);
        run_period(0, 0, -1, l, r, 10);
    endtask

    function automatic int rand_cmd(input int prev);
        int sel;
        int v;
        sel = int'($urandom_range(0, 5));
        case (sel)
            0:       v = 0;
            1:       v = -1024;
            2:       v = 1023;
            3:       v = (prev == -1024) ? 1023 : -prev;
            default: v = int'($urandom_range(0, 2047)) - 1024;
        endcase
        return v;
    endfunction

    // Monitor: pops one expectation per period and checks every cycle of it.
    initial begin
        int   pos;
        int   pidx;
        bit   have;
        exp_t e;
        int   hi[4];
        int   bad[4];
        int   want[4];
        int   ovl[2];
        int   prd_bad;
        logic [3:0] pins;
        bit   w;
        bit   pin;
        pos = 0;
        pidx = 0;
        have = 0;
        prd_bad = 0;
        e.fl = 0; e.rl = 0; e.fr = 0; e.rr = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pos  = 0;
                pidx = 0;
                have = 0;
                continue;
            end
            if (pos == 0) begin
                for (int k = 0; k < 4; k++) begin
                    hi[k]  = 0;
                    bad[k] = 0;
                end
                ovl[0]  = 0;
                ovl[1]  = 0;
                prd_bad = 0;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL exp_queue: period %0d has no expected entry", pidx);
                    have = 0;
                end else begin
                    e    = exp_q.pop_front();
                    have = 1;
                end
            end
            pins = {fwd_lft, rev_lft, fwd_rht, rev_rht};
            want = '{e.fl, e.rl, e.fr, e.rr};
            for (int k = 0; k < 4; k++) begin
                w   = (pos >= 1) && (pos <= want[k]);
                pin = pins[3-k];
                if (pin) hi[k]++;
                if (pin != w) bad[k]++;
            end
            if (fwd_lft && rev_lft) ovl[0]++;
            if (fwd_rht && rev_rht) ovl[1]++;
            if (prd_strt != ((pos == 0) && (pidx > 0))) prd_bad++;
            if (pos == PRD - 1) begin
                if (have) begin
                    for (int k = 0; k < 4; k++) begin
                        checks++;
                        if (bad[k] != 0) begin
                            errors++;
                            $display("FAIL %s period %0d: high %0d cycles, expected %0d (cycles off %0d)",
                                     pin_name[k], pidx, hi[k], want[k], bad[k]);
                        end
                    end
                end
                check_eq("overlap_lft", ovl[0], 0);
                check_eq("overlap_rht", ovl[1], 0);
                check_eq("prd_strt_cycles_off", prd_bad, 0);
                pidx++;
            end
            pos = (pos + 1) % PRD;
        end
    end

    // Stimulus: directed scenarios, mid-period reset, then randomized commands.
    initial begin
        int l;
        int r;
        int mp;
        int fp;
        model_reset();
        #1 rst_n = 1'b0;
        #1;
        check_eq("reset_outputs", int'({fwd_lft, rev_lft, fwd_rht, rev_rht, prd_strt}), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        push_zero();

        // forward / reverse basics
        run(256, -256);
        run(256, -256);
        // saturation with reversal dead-time, then full-scale forward, then zero
        run(-1024, -256);
        run(-1024, -256);
        run(1023, -256);
        run(1023, -256);
        run(0, -256);
        // double-buffer: change at cnt=300 only takes effect next period
        run(256, 256);
        run_period(0, 0, -1, 512, 256, 300);
        run(512, 256);
        // +512 then -512 inside one period
        run_period(512, 256, 100, -512, 256, 600);
        run(-512, 256);
        run(512, 256);
        run(512, 256);
        // reversal through coast: no dead period
        run(0, 256);
        run(-512, 256);
        // simultaneous reversals, then reversal while dead
        run(300, -300);
        run(-300, 300);
        run(-300, 300);
        run(-300, 500);

        // reset in mid-period while fwd_rht is driving
        repeat (100) tick();
        check_eq("fwd_rht_before_reset", int'(fwd_rht), 1);
        rst_n = 1'b0;
        #1;
        check_eq("async_reset_outputs", int'({fwd_lft, rev_lft, fwd_rht, rev_rht, prd_strt}), 0);
        exp_q.delete();
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        push_zero();
        run(200, -700);
        run(200, -700);

        // randomized commands with glitches before the final value
        l = 200;
        r = -700;
        for (int i = 0; i < 20; i++) begin
            l  = rand_cmd(l);
            r  = rand_cmd(r);
            mp = int'($urandom_range(0, 511));
            fp = int'($urandom_range(512, PRD - 1));
            run_period(int'($urandom_range(0, 2047)) - 1024, int'($urandom_range(0, 2047)) - 1024,
                       mp, l, r, fp);
        end

        repeat (PRD) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
